march_multi_engine: RTL and testbench

MARCH_MULTI_ENGINE -- requirements
Module: march_multi_engine

---
 rtl/march_multi_engine.sv | 215 +++++++++++++++++++++
 tb/tb_march_multi_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/march_multi_engine.sv
// MATS+ / March X / March C- memory BIST engine; MARCH_FAIL_LOG_EN adds first-fail address/syndrome capture.
// Latency: one memory op per cycle in RUN; each read is compared the cycle after issue, and one drain cycle follows the last op.
// Backpressure: none; the memory must accept an op every cycle, and a mismatch past the allowance stops issue that same cycle.
module march_multi_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            alg_sel,
    input  logic [ADDR_WIDTH-1:0] addr_max,
    input  logic [ADDR_WIDTH-1:0] allowable_faulty,
    input  logic                  error_exceed_ignore,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] fail_count,
    output logic                  force_terminate,
    output logic                  complete,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [DATA_WIDTH-1:0] first_fail_syndrome
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

    // rd: first op is a read of val; two: read is followed by a write of ~val.
    typedef struct packed {
        logic down;
        logic two;
        logic rd;
        logic val;
        logic last;
    } elem_t;

    function automatic elem_t elem_info(input logic [1:0] alg, input logic [2:0] idx);
        elem_t e;
        e = '{down: 1'b0, two: 1'b0, rd: 1'b1, val: 1'b0, last: 1'b0};
        if (alg == 2'd0 || alg == 2'd1) begin
            case (idx)
                3'd0: e.rd = 1'b0;
                3'd1: e.two = 1'b1;
                3'd2: begin e.two = 1'b1; e.val = 1'b1; e.down = 1'b1; e.last = (alg == 2'd0); end
                default: e.last = 1'b1;
            endcase
        end else begin
            case (idx)
                3'd0: e.rd = 1'b0;
                3'd1: e.two = 1'b1;
                3'd2: begin e.two = 1'b1; e.val = 1'b1; end
                3'd3: begin e.two = 1'b1; e.down = 1'b1; end
                3'd4: begin e.two = 1'b1; e.val = 1'b1; e.down = 1'b1; end
                default: e.last = 1'b1;
            endcase
        end
        return e;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            alg_q, alg_d;
    logic [ADDR_WIDTH-1:0] amax_q, amax_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  op_q, op_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_exp_q, rd_exp_d;
    logic [ADDR_WIDTH-1:0] fail_count_q, fail_count_d;
    logic                  force_q, force_d;

    elem_t                 cur_e, nxt_e;
    logic                  cur_wr, cur_val, elem_done, at_end, seq_done;
    logic                  mismatch, kill, issue;
    logic [ADDR_WIDTH-1:0] cnt_inc;

    always_comb begin
        cur_e     = elem_info(alg_q, elem_q);
        nxt_e     = elem_info(alg_q, elem_q + 3'd1);
        cur_wr    = ~cur_e.rd | op_q;
        cur_val   = op_q ? ~cur_e.val : cur_e.val;
        elem_done = ~cur_e.two | op_q;
        at_end    = cur_e.down ? (addr_q == '0) : (addr_q == amax_q);
        seq_done  = elem_done & at_end & cur_e.last;
        mismatch  = rd_pend_q & (rdata != {DATA_WIDTH{rd_exp_q}});
        cnt_inc   = (&fail_count_q) ? fail_count_q : fail_count_q + ADDR_WIDTH'(1);
        kill      = mismatch & ~error_exceed_ignore & (cnt_inc > allowable_faulty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            alg_q        <= '0;
            amax_q       <= '0;
            elem_q       <= '0;
            addr_q       <= '0;
            op_q         <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_exp_q     <= 1'b0;
            fail_count_q <= '0;
            force_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            alg_q        <= alg_d;
            amax_q       <= amax_d;
            elem_q       <= elem_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            rd_pend_q    <= rd_pend_d;
            rd_exp_q     <= rd_exp_d;
            fail_count_q <= fail_count_d;
            force_q      <= force_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (kill)          state_d = S_DONE;
                else if (seq_done) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alg_d        = alg_q;
        amax_d       = amax_q;
        elem_d       = elem_q;
        addr_d       = addr_q;
        op_d         = op_q;
        rd_pend_d    = 1'b0;
        rd_exp_d     = rd_exp_q;
        fail_count_d = mismatch ? cnt_inc : fail_count_q;
        force_d      = force_q | kill;
        if (state_q == S_IDLE && start) begin
            alg_d        = alg_sel;
            amax_d       = addr_max;
            elem_d       = '0;
            addr_d       = '0;
            op_d         = 1'b0;
            fail_count_d = '0;
            force_d      = 1'b0;
        end else if (state_q == S_RUN && !kill) begin
            rd_pend_d = ~cur_wr;
            rd_exp_d  = cur_val;
            if (!elem_done) begin
                op_d = 1'b1;
            end else begin
                op_d = 1'b0;
                if (!at_end) begin
                    addr_d = cur_e.down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
                end else if (!cur_e.last) begin
                    elem_d = elem_q + 3'd1;
                    addr_d = nxt_e.down ? amax_q : '0;
                end
            end
        end
    end

    always_comb begin
        issue           = (state_q == S_RUN) & ~kill;
        mem_en          = issue;
        write_read      = issue & cur_wr;
        address         = issue ? addr_q : '0;
        wdata           = issue ? {DATA_WIDTH{cur_val}} : '0;
        busy            = (state_q == S_RUN) | (state_q == S_DRAIN);
        complete        = (state_q == S_DONE);
        error           = mismatch;
        fail_count      = fail_count_q;
        force_terminate = force_q;
    end

`ifdef MARCH_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, ffa_q, ffa_d;
    logic [DATA_WIDTH-1:0] ffs_q, ffs_d;

    // fail_count still zero means this mismatch is the first of the run.
    always_comb begin
        rd_addr_d = addr_q;
        ffa_d     = ffa_q;
        ffs_d     = ffs_q;
        if (state_q == S_IDLE && start) begin
            ffa_d = '0;
            ffs_d = '0;
        end else if (mismatch && fail_count_q == '0) begin
            ffa_d = rd_addr_q;
            ffs_d = rdata ^ {DATA_WIDTH{rd_exp_q}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            ffa_q     <= '0;
            ffs_q     <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            ffa_q     <= ffa_d;
            ffs_q     <= ffs_d;
        end
    end

    assign first_fail_addr     = ffa_q;
    assign first_fail_syndrome = ffs_q;
`else
    assign first_fail_addr     = '0;
    assign first_fail_syndrome = '0;
`endif

endmodule

// File: tb/tb_march_multi_engine.sv
// Directed bench for march_multi_engine: op-stream model built from the algorithm element lists, per-cycle compare.
module tb_march_multi_engine;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam logic [DW-1:0] FAULT_MASK = 64'h20;
    localparam int FAULT_ADDR = 2;

    logic          clk;
    logic          rst_n, start, error_exceed_ignore;
    logic [1:0]    alg_sel;
    logic [AW-1:0] addr_max, allowable_faulty;
    logic [DW-1:0] rdata;
    logic          mem_en, write_read, busy, error, force_terminate, complete;
    logic [AW-1:0] address, fail_count, first_fail_addr;
    logic [DW-1:0] wdata, first_fail_syndrome;

    march_multi_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alg_sel(alg_sel), .addr_max(addr_max),
        .allowable_faulty(allowable_faulty), .error_exceed_ignore(error_exceed_ignore),
        .rdata(rdata), .mem_en(mem_en), .write_read(write_read), .address(address),
        .wdata(wdata), .busy(busy), .error(error), .fail_count(fail_count),
        .force_terminate(force_terminate), .complete(complete),
        .first_fail_addr(first_fail_addr), .first_fail_syndrome(first_fail_syndrome)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Memory with one-cycle read latency; optional bit-5 stuck-at-1 at FAULT_ADDR.
    logic [DW-1:0] mem [0:15];
    bit fault_en;
    always @(posedge clk) begin
        if (mem_en) begin
            if (write_read) mem[address[3:0]] <= wdata;
            else rdata <= mem[address[3:0]] | ((fault_en && address == FAULT_ADDR) ? FAULT_MASK : '0);
        end
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic          val;
    } op_t;
    op_t exp_q[$];

    task automatic add_elem(input bit down, input bit two, input bit rd, input bit v, input int n);
        op_t o;
        for (int k = 0; k < n; k++) begin
            o.addr = AW'(down ? n - 1 - k : k);
            o.wr   = !rd;
            o.val  = v;
            exp_q.push_back(o);
            if (two) begin
                o.wr  = 1'b1;
                o.val = !v;
                exp_q.push_back(o);
            end
        end
    endtask

    task automatic build(input int alg, input int n);
        exp_q.delete();
        add_elem(0, 0, 0, 0, n);              // up w0
        add_elem(0, 1, 1, 0, n);              // up r0,w1
        if (alg == 0) begin
            add_elem(1, 1, 1, 1, n);          // down r1,w0
        end else if (alg == 1) begin
            add_elem(1, 1, 1, 1, n);          // down r1,w0
            add_elem(0, 0, 1, 0, n);          // up r0
        end else begin
            add_elem(0, 1, 1, 1, n);          // up r1,w0
            add_elem(1, 1, 1, 0, n);          // down r0,w1
            add_elem(1, 1, 1, 1, n);          // down r1,w0
            add_elem(0, 0, 1, 0, n);          // up r0
        end
    endtask

    bit mon_en;
    int op_idx, err_seen, cmp_seen;
    bit pend, pend_val, exp_err;
    logic [AW-1:0] pend_addr;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_err = pend && fault_en && pend_addr == FAULT_ADDR && pend_val == 1'b0;
            check("error_pulse", error, exp_err);
            if (error) err_seen++;
            if (complete) cmp_seen++;
            pend = 1'b0;
            if (mem_en) begin
                if (op_idx < exp_q.size()) begin
                    check("op_write_read", write_read, exp_q[op_idx].wr);
                    check("op_address", address, exp_q[op_idx].addr);
                    if (exp_q[op_idx].wr) check("op_wdata", wdata, {DW{exp_q[op_idx].val}});
                    else begin
                        pend      = 1'b1;
                        pend_addr = exp_q[op_idx].addr;
                        pend_val  = exp_q[op_idx].val;
                    end
                end else begin
                    check("extra_op", mem_en, 0);
                end
                op_idx++;
            end else begin
                check("idle_bus_zero", (write_read || address != 0 || wdata != 0), 0);
            end
        end
    end

    task automatic arm(input int alg, input int amax, input int allow, input bit ign, input bit flt);
        build(alg == 3 ? 2 : alg, amax + 1);
        fault_en            = flt;
        alg_sel             = 2'(alg);
        addr_max            = AW'(amax);
        allowable_faulty    = AW'(allow);
        error_exceed_ignore = ign;
        op_idx = 0; err_seen = 0; cmp_seen = 0; pend = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string tag, input int alg, input int amax, input int allow, input bit ign,
                       input bit flt, input bit poke, input int exp_ops, input int exp_fails, input bit exp_force);
        int cyc;
        arm(alg, amax, allow, ign, flt);
        check({tag, ":busy_after_start"}, busy, 1);
        alg_sel  = alg_sel ^ 2'b11;
        addr_max = addr_max ^ AW'(1);
        if (poke) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (!complete && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ":complete_seen"}, complete, 1);
        check({tag, ":busy_in_done"}, busy, 0);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check({tag, ":op_count"}, op_idx, exp_ops);
        check({tag, ":error_pulses"}, err_seen, exp_fails);
        check({tag, ":fail_count"}, fail_count, exp_fails);
        check({tag, ":force_terminate"}, force_terminate, exp_force);
        check({tag, ":complete_pulses"}, cmp_seen, 1);
        check({tag, ":busy_idle"}, busy, 0);
`ifdef MARCH_FAIL_LOG_EN
        check({tag, ":first_fail_addr"}, first_fail_addr, exp_fails != 0 ? FAULT_ADDR : 0);
        check({tag, ":first_fail_syn"}, first_fail_syndrome, exp_fails != 0 ? FAULT_MASK : '0);
`else
        check({tag, ":first_fail_addr"}, first_fail_addr, 0);
        check({tag, ":first_fail_syn"}, first_fail_syndrome, 0);
`endif
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; alg_sel = '0; addr_max = '0;
        allowable_faulty = '0; error_exceed_ignore = 1'b0; fault_en = 1'b0; mon_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_complete", complete, 0);
        check("rst_error", error, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_force", force_terminate, 0);
        check("rst_ffa", first_fail_addr, 0);
        rst_n = 1'b1;

        // Hand-derived sizes and orderings of the reference sequences.
        build(0, 4);
        check("model_mats_len", exp_q.size(), 20);
        check("model_mats_down_start", exp_q[12].addr, 3);
        build(1, 4);
        check("model_marchx_len", exp_q.size(), 24);
        build(2, 4);
        check("model_marchc_len", exp_q.size(), 40);
        check("model_marchc_last_addr", exp_q[39].addr, 3);
        build(2, 1);
        check("model_n1_len", exp_q.size(), 10);

        run("marchc",       2, 3, 0, 0, 0, 0, 40, 0, 0);
        run("mats",         0, 3, 0, 0, 0, 0, 20, 0, 0);
        run("marchx",       1, 3, 0, 0, 0, 0, 24, 0, 0);
        run("alg3",         3, 3, 0, 0, 0, 0, 40, 0, 0);
        run("fault_stop",   2, 3, 0, 0, 1, 0,  9, 1, 1);
        run("fault_ignore", 2, 3, 0, 1, 1, 0, 40, 3, 0);
        run("fault_allow2", 2, 3, 2, 0, 1, 0, 39, 3, 1);
        run("fault_allow3", 2, 3, 3, 0, 1, 0, 40, 3, 0);

        // Reset in the middle of a run, once 17 ops have gone out.
        arm(2, 3, 0, 0, 0);
        cyc = 0;
        while (op_idx < 17 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_reached_op17", op_idx >= 17, 1);
        rst_n  = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_mem_en", mem_en, 0);
        check("midrst_fail_count", fail_count, 0);
        check("midrst_complete", complete, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_rst",    2, 3, 0, 0, 0, 0, 40, 0, 0);
        run("n1_poke",      2, 0, 0, 0, 0, 1, 10, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
